// File: rtl/cfg_ls_stream_sel_loader_if.sv
// Handshake bundle for cfg_ls_stream_sel_loader.
//   start_i / base_addr_i / n_entries_i : load command (sampled together)
//   cfg_valid_i / cfg_data_i / cfg_ready_o : configuration word stream
//   busy_o / done_o : load status
// master drives the command and stream; slave is the loader.
interface cfg_ls_stream_sel_loader_if #(
  parameter int N_ADDR_BITS_KMEM = 4
);
  logic                        start_i;
  logic [N_ADDR_BITS_KMEM-1:0] base_addr_i;
  logic [N_ADDR_BITS_KMEM:0]   n_entries_i;
  logic                        cfg_valid_i;
  logic [31:0]                 cfg_data_i;
  logic                        cfg_ready_o;
  logic                        busy_o;
  logic                        done_o;

  modport slave (
    input  start_i, base_addr_i, n_entries_i, cfg_valid_i, cfg_data_i,
    output cfg_ready_o, busy_o, done_o
  );

  modport master (
    output start_i, base_addr_i, n_entries_i, cfg_valid_i, cfg_data_i,
    input  cfg_ready_o, busy_o, done_o
  );
endinterface

// File: rtl/cfg_ls_stream_sel_loader.sv
// Load/store stream-select configuration writer.
// A start command latches a base kmem entry and an entry count, then each
// accepted 32-bit word fills one (bank group, bank) slot of the current entry:
// bits [LOG_N_AGE_PER_STREAM-1:0] -> load select, bits [16 +: LOG_N_PE_PER_GROUP]
// -> store select. Bank is the fastest index, then group, then entry.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   bus (slave)                  command, word stream, ready/busy/done
//   reg_cfg_l_stream_sel_o       [group][bank][entry] load select array
//   reg_cfg_s_stream_sel_o       [group][bank][entry] store select array
module cfg_ls_stream_sel_loader #(
  parameter int N_BANKS_GROUP        = 4,
  parameter int N_BANKS_PER_STREAM   = 2,
  parameter int KMEM_SIZE            = 16,
  parameter int N_ADDR_BITS_KMEM     = 4,
  parameter int LOG_N_AGE_PER_STREAM = 2,
  parameter int LOG_N_PE_PER_GROUP   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  cfg_ls_stream_sel_loader_if.slave bus,
  output logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_AGE_PER_STREAM-1:0]
               reg_cfg_l_stream_sel_o,
  output logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_PE_PER_GROUP-1:0]
               reg_cfg_s_stream_sel_o
);
  localparam int AW = N_ADDR_BITS_KMEM;
  localparam int CW = N_ADDR_BITS_KMEM + 1;
  localparam int GW = (N_BANKS_GROUP > 1) ? $clog2(N_BANKS_GROUP) : 1;
  localparam int BW = (N_BANKS_PER_STREAM > 1) ? $clog2(N_BANKS_PER_STREAM) : 1;
  localparam logic [31:0] USED_MASK =
    ((32'd1 << LOG_N_AGE_PER_STREAM) - 32'd1) | (((32'd1 << LOG_N_PE_PER_GROUP) - 32'd1) << 16);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  typedef logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_AGE_PER_STREAM-1:0] l_arr_t;
  typedef logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_PE_PER_GROUP-1:0]   s_arr_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gi_q, gi_d;
  logic [BW-1:0]   bj_q, bj_d;
  l_arr_t          l_q, l_d;
  s_arr_t          s_q, s_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Bits outside the two select fields carry no meaning.
  logic [31:0] data_unused_bits;
  assign data_unused_bits = bus.cfg_data_i & ~USED_MASK;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gi_d    = gi_q;
    bj_d    = bj_q;
    l_d     = l_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.n_entries_i == '0) begin
            state_d = DONE;
          end else begin
            ptr_d   = bus.base_addr_i;
            // Counts beyond the table size would only rewrite wrapped entries.
            cnt_d   = (bus.n_entries_i > CW'(KMEM_SIZE)) ? CW'(KMEM_SIZE) : bus.n_entries_i;
            gi_d    = '0;
            bj_d    = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.cfg_valid_i) begin
          l_d[gi_q][bj_q][ptr_q] = bus.cfg_data_i[LOG_N_AGE_PER_STREAM-1:0];
          s_d[gi_q][bj_q][ptr_q] = bus.cfg_data_i[16 +: LOG_N_PE_PER_GROUP];
          if (bj_q == BW'(N_BANKS_PER_STREAM-1)) begin
            bj_d = '0;
            if (gi_q == GW'(N_BANKS_GROUP-1)) begin
              gi_d  = '0;
              ptr_d = (ptr_q == AW'(KMEM_SIZE-1)) ? '0 : ptr_q + 1'b1;
              cnt_d = cnt_q - 1'b1;
              if (cnt_q == CW'(1)) state_d = DONE;
            end else begin
              gi_d = gi_q + 1'b1;
            end
          end else begin
            bj_d = bj_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered decodes of the next state.
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gi_q    <= '0;
      bj_q    <= '0;
      l_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gi_q    <= gi_d;
      bj_q    <= bj_d;
      l_q     <= l_d;
      s_q     <= s_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.cfg_ready_o         = ready_q;
  assign bus.busy_o              = busy_q;
  assign bus.done_o              = done_q;
  assign reg_cfg_l_stream_sel_o  = l_q;
  assign reg_cfg_s_stream_sel_o  = s_q;
endmodule

// File: tb/tb_cfg_ls_stream_sel_loader.sv
module tb_cfg_ls_stream_sel_loader;
  localparam int NG = 4, NB = 2, KM = 16, AB = 4, LW = 2, SW = 2;
  localparam int SLOTS = NG * NB;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [NG-1:0][NB-1:0][KM-1:0][LW-1:0] l_o;
  logic [NG-1:0][NB-1:0][KM-1:0][SW-1:0] s_o;

  cfg_ls_stream_sel_loader_if #(.N_ADDR_BITS_KMEM(AB)) bus ();

  cfg_ls_stream_sel_loader #(
    .N_BANKS_GROUP(NG), .N_BANKS_PER_STREAM(NB), .KMEM_SIZE(KM),
    .N_ADDR_BITS_KMEM(AB), .LOG_N_AGE_PER_STREAM(LW), .LOG_N_PE_PER_GROUP(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .reg_cfg_l_stream_sel_o(l_o), .reg_cfg_s_stream_sel_o(s_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  // Reference table: [group][bank][entry]
  int ml[NG][NB][KM];
  int ms[NG][NB][KM];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic rdy, input logic bsy, input logic dn);
    chk({tag, " ready"}, 32'(bus.cfg_ready_o), 32'(rdy));
    chk({tag, " busy"},  32'(bus.busy_o),      32'(bsy));
    chk({tag, " done"},  32'(bus.done_o),      32'(dn));
  endtask

  task automatic check_arrays(input string tag);
    for (int g = 0; g < NG; g++)
      for (int b = 0; b < NB; b++)
        for (int e = 0; e < KM; e++) begin
          chk($sformatf("%s l[%0d][%0d][%0d]", tag, g, b, e), 32'(l_o[g][b][e]), 32'(ml[g][b][e]));
          chk($sformatf("%s s[%0d][%0d][%0d]", tag, g, b, e), 32'(s_o[g][b][e]), 32'(ms[g][b][e]));
        end
  endtask

  function automatic void model_clear();
    for (int g = 0; g < NG; g++)
      for (int b = 0; b < NB; b++)
        for (int e = 0; e < KM; e++) begin
          ml[g][b][e] = 0;
          ms[g][b][e] = 0;
        end
  endfunction

  // Word number w of a load lands in entry (base + w/8) mod 16,
  // group (w%8)/NB, bank w%NB.
  function automatic void model_load(input int base, input int n, input logic [31:0] w[$]);
    int ne, ent, idx;
    ne = (n > KM) ? KM : n;
    for (int e = 0; e < ne; e++)
      for (int g = 0; g < NG; g++)
        for (int b = 0; b < NB; b++) begin
          idx = e * SLOTS + g * NB + b;
          ent = (base + e) % KM;
          ml[g][b][ent] = int'(w[idx]) & 3;
          ms[g][b][ent] = int'(w[idx] >> 16) & 3;
        end
  endfunction

  task automatic run_load(input string tag, input int base, input int n,
                          input logic [31:0] words[$], input int gap_pct, input bit poke);
    int ne;
    ne = (n > KM) ? KM : n;
    bus.start_i     = 1'b1;
    bus.base_addr_i = AB'(base);
    bus.n_entries_i = (AB+1)'(n);
    tick();
    bus.start_i = 1'b0;
    if (ne == 0) begin
      check_ctrl({tag, " n0"}, 1'b0, 1'b1, 1'b1);
      tick();
      check_ctrl({tag, " n0 idle"}, 1'b0, 1'b0, 1'b0);
      check_arrays({tag, " n0"});
      return;
    end
    check_ctrl({tag, " start"}, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < ne * SLOTS; i++) begin
      for (int gp = 0; gp < 4 && gap_pct > 0 && $urandom_range(99) < gap_pct; gp++) begin
        bus.cfg_valid_i = 1'b0;
        bus.cfg_data_i  = $urandom;
        bus.start_i     = poke & $urandom_range(1);
        bus.base_addr_i = AB'($urandom);
        bus.n_entries_i = (AB+1)'($urandom);
        tick();
      end
      chk($sformatf("%s ready w%0d", tag, i), 32'(bus.cfg_ready_o), 32'd1);
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = words[i];
      bus.start_i     = poke & $urandom_range(1);
      tick();
    end
    bus.cfg_valid_i = 1'b0;
    bus.start_i     = 1'b0;
    model_load(base, n, words);
    check_ctrl({tag, " done"}, 1'b0, 1'b1, 1'b1);
    tick();
    check_ctrl({tag, " idle"}, 1'b0, 1'b0, 1'b0);
    check_arrays(tag);
  endtask

  task automatic basic_load(input string tag);
    logic [31:0] w[$];
    logic [1:0] kl, kh;
    for (int k = 0; k < SLOTS; k++) begin
      kl = 2'(k);
      kh = 2'(k + 1);
      w.push_back({14'b0, kl, 14'b0, kh});
    end
    run_load(tag, 3, 1, w, 0, 1'b0);
    for (int k = 0; k < SLOTS; k++) begin
      chk($sformatf("%s l k%0d", tag, k), 32'(l_o[k/2][k%2][3]), 32'((k + 1) % 4));
      chk($sformatf("%s s k%0d", tag, k), 32'(s_o[k/2][k%2][3]), 32'(k % 4));
      chk($sformatf("%s e2 l k%0d", tag, k), 32'(l_o[k/2][k%2][2]), 32'd0);
      chk($sformatf("%s e4 s k%0d", tag, k), 32'(s_o[k/2][k%2][4]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w[$];
    int base, n;

    bus.start_i = 1'b0; bus.base_addr_i = '0; bus.n_entries_i = '0;
    bus.cfg_valid_i = 1'b0; bus.cfg_data_i = '0;
    model_clear();

    // Reset held with garbage on the inputs: reset must win.
    bus.start_i = 1'b1; bus.n_entries_i = 5'd3; bus.cfg_valid_i = 1'b1; bus.cfg_data_i = '1;
    tick(); tick();
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check_arrays("reset");
    bus.start_i = 1'b0; bus.cfg_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();

    basic_load("basic");

    // Words offered while idle are not taken.
    for (int i = 0; i < 3; i++) begin
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = 32'hFFFF_FFFF;
      tick();
      chk($sformatf("idle ready %0d", i), 32'(bus.cfg_ready_o), 32'd0);
    end
    bus.cfg_valid_i = 1'b0;
    check_arrays("idle words");

    // Wrap from entry 15 to 0.
    w.delete();
    for (int i = 0; i < 2 * SLOTS; i++) w.push_back(32'h0003_0002);
    run_load("wrap", 15, 2, w, 0, 1'b0);
    chk("wrap l e15", 32'(l_o[2][1][15]), 32'd2);
    chk("wrap s e0",  32'(s_o[0][0][0]),  32'd3);

    run_load("zero", 7, 0, w, 0, 1'b0);

    // Random loads with valid gaps and stray start pulses.
    for (int r = 0; r < 4; r++) begin
      base = int'($urandom_range(KM - 1));
      n    = int'($urandom_range(1, 4));
      w.delete();
      for (int i = 0; i < n * SLOTS; i++) w.push_back($urandom);
      run_load($sformatf("rand%0d", r), base, n, w, 40, 1'b1);
    end

    // Oversized count clamps to a full table.
    w.delete();
    for (int i = 0; i < KM * SLOTS; i++) w.push_back($urandom);
    run_load("clamp", int'($urandom_range(KM - 1)), 20, w, 10, 1'b0);

    // Reset after the 5th word aborts the load and clears everything.
    bus.start_i = 1'b1; bus.base_addr_i = 4'd3; bus.n_entries_i = 5'd1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = 32'h0001_0003;
      tick();
    end
    bus.cfg_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_clear();
    check_ctrl("midrst", 1'b0, 1'b0, 1'b0);
    check_arrays("midrst");
    basic_load("after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfg_ls_stream_sel_loader.md
# cfg_ls_stream_sel_loader

Configuration writer for the load/store stream-select register file. Accepts a start command (base kernel-memory address, entry count), then consumes a valid/ready stream of 32-bit configuration words. Each word is unpacked into the load-stream and store-stream select fields of one (bank group, bank) slot of one kernel-memory entry. Outputs the full register arrays that the per-cycle stream-select mux indexes with the reconfiguration controller address.

## Interface

Parameters (defaults come from pea_pkg/mage_pkg/xbar_pkg; the values below are the ones used by the bench):
- N_BANKS_GROUP, 4: number of bank groups.
- N_BANKS_PER_STREAM, 2: banks per stream.
- KMEM_SIZE, 16: kernel-memory entries.
- N_ADDR_BITS_KMEM, 4: equals log2(KMEM_SIZE).
- LOG_N_AGE_PER_STREAM, 2: width of the load select field.
- LOG_N_PE_PER_GROUP, 2: width of the store select field.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle load command.
- base_addr_i  in  N_ADDR_BITS_KMEM  first kmem entry to write; sampled with start_i.
- n_entries_i  in  N_ADDR_BITS_KMEM+1  number of entries to write; sampled with start_i.
- cfg_valid_i  in  1  configuration word valid.
- cfg_data_i  in  32  configuration word.
- cfg_ready_o  out  1  word accepted when valid and ready are both high.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse when a load completes.
- reg_cfg_l_stream_sel_o  out  [N_BANKS_GROUP][N_BANKS_PER_STREAM][KMEM_SIZE][LOG_N_AGE_PER_STREAM]  load select array.
- reg_cfg_s_stream_sel_o  out  [N_BANKS_GROUP][N_BANKS_PER_STREAM][KMEM_SIZE][LOG_N_PE_PER_GROUP]  store select array.

## Operation

- FSM states: IDLE, LOAD, DONE.
- IDLE: cfg_ready_o=0, busy_o=0.
  - On start_i with n_entries_i=0: go to DONE and write nothing.
  - On start_i otherwise: latch the address pointer = base_addr_i and the entry counter = min(n_entries_i, KMEM_SIZE); clear the group index gi and bank index bj; go to LOAD.
- LOAD: cfg_ready_o=1, busy_o=1.
  - Each handshake writes cfg_data_i[LOG_N_AGE_PER_STREAM-1:0] into l[gi][bj][ptr] and cfg_data_i[16+LOG_N_PE_PER_GROUP-1:16] into s[gi][bj][ptr]. All other data bits are ignored.
  - Word order: bj is the innermost index, then gi, then ptr. That gives N_BANKS_GROUP*N_BANKS_PER_STREAM words per entry.
  - After the last slot of an entry: ptr increments modulo KMEM_SIZE (wraps 15→0) and the counter decrements.
  - On the handshake that finishes the last entry: go to DONE.
  - A cycle with no handshake holds all state.
- DONE: done_o=1 and busy_o=1 for one cycle, cfg_ready_o=0; then return to IDLE.
- start_i is ignored in LOAD and DONE.
- cfg_valid_i is ignored (no handshake) in IDLE and DONE.
- Entries and slots not addressed by a load keep their previous values.

## Timing

- Reset: all array elements 0; cfg_ready_o=0, busy_o=0, done_o=0; state IDLE. Reset has priority over every other input in the same cycle.
- A reset in the middle of a load aborts it. Every array element returns to 0, including entries already written.
- start_i at edge t: cfg_ready_o=1 and busy_o=1 from cycle t+1.
- Word accepted at edge t: the new value is visible on the array outputs from t+1. There is no combinational path from cfg_data_i to the outputs.
- cfg_ready_o is a registered state decode. It does not depend on cfg_valid_i.
- Final handshake at edge t: done_o=1 in cycle t+1; IDLE and ready for start_i in cycle t+2.
- With n_entries_i=0: done_o=1 in the cycle after start_i.
- Back-to-back valid: one word per cycle. A full 16-entry load takes 128 handshake cycles, plus 1 cycle for start and 1 for DONE.

## Test plan

- Reset, then read: every l/s element is 0; ready, busy and done are all 0.
- Basic load: start, base=3, n=1; 8 words with data = {14'b0, k[1:0], 14'b0, (k+1)[1:0]} for k=0..7.
  - Required: l[k/2][k%2][3]=(k+1)%4 and s[k/2][k%2][3]=k%4.
  - Required: entry 2 and entry 4 stay 0; done_o pulses exactly once, 1 cycle after the 8th word.
- Wrap-around: base=15, n=2, 16 words all with data=0x0003_0002. Required: entries 15 and 0 hold l=2 and s=3; entry 1 stays unchanged.
- Backpressure and ignoring: random valid gaps during a load give the same final array as back-to-back words. start_i asserted mid-load has no effect. Words presented in IDLE are not accepted (cfg_ready_o=0).
- Edge counts:
  - n=0: done_o one cycle after start, no writes.
  - n=20: clamps to 16 entries and completes after 128 words.
- Reset mid-load: assert rst_i after the 5th word. Required: all outputs 0 next cycle; a fresh start then behaves as in the basic load.
